// File: rtl/uart_tx_fifo.sv
// Parametrised UART TX: start, 1..DATA_W data bits LSB first, optional parity (UART_TX_PARITY_EN), 1/2 stop bits.
// Latency: a byte pushed into an empty FIFO at edge N drives the start bit after edge N+1; queued frames run gapless.
// Backpressure: in_ready is !full from the registered level (no bypass), low while rst_n is low.

// Generic synchronous FIFO: power-of-2 depth, registered occupancy count.
// Latency: pushed data is visible at the head on the next cycle; no fall-through path.
// Backpressure: push_rdy drops at full and stays low until the cycle after reset release.
module uart_tx_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_vld,
  output logic                    push_rdy,
  input  logic [W-1:0]            push_dat,
  output logic                    pop_vld,
  input  logic                    pop_rdy,
  output logic [W-1:0]            pop_dat,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          en;
  logic          push;
  logic          pop;

  assign push_rdy = rst_n & en & (count != (AW+1)'(DEPTH));
  assign pop_vld  = (count != '0);
  assign push     = push_vld & push_rdy;
  assign pop      = pop_rdy & pop_vld;
  assign pop_dat  = mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      en     <= 1'b0;
    end else begin
      en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic [3:0]                   cfg_bits,
  input  logic                         cfg_stop2,
  input  logic [1:0]                   cfg_par,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  cnt, cnt_nxt;
  logic [DIV_W-1:0]  div_q, div_nxt;
  logic [BW-1:0]     idx, idx_nxt;
  logic [BW-1:0]     bits_q, bits_nxt;
  logic              stop2_q, stop2_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt, shreg_sh;
  logic              tx_nxt, busy_nxt;
  logic              fifo_vld, pop, bit_end, start_frame;
  logic [DATA_W-1:0] fifo_dat;
  logic [DIV_W-1:0]  div_eff;
  logic [BW-1:0]     bits_eff;

  uart_tx_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (in_data),
    .pop_vld  (fifo_vld),
    .pop_rdy  (pop),
    .pop_dat  (fifo_dat),
    .level    (fifo_level)
  );

  assign div_eff  = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign bits_eff = (cfg_bits == 4'd0 || int'(cfg_bits) > DATA_W) ? BW'(DATA_W) : BW'(cfg_bits);
  assign bit_end  = (cnt == div_q - DIV_W'(1));
  assign shreg_sh = shreg >> 1;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_nxt;
  logic par_bit_q, par_bit_nxt;
  logic par_calc;

  // Parity covers only the bits that will actually be sent.
  always_comb begin
    par_calc = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i < int'(bits_eff)) par_calc = par_calc ^ fifo_dat[i];
  end
`else
  logic unused_par;
  assign unused_par = ^cfg_par;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    div_nxt     = div_q;
    bits_nxt    = bits_q;
    stop2_nxt   = stop2_q;
    shreg_nxt   = shreg;
    tx_nxt      = tx;
    busy_nxt    = busy;
    pop         = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_nxt  = par_en_q;
    par_bit_nxt = par_bit_q;
`endif
    if (state != S_IDLE) cnt_nxt = bit_end ? '0 : cnt + DIV_W'(1);

    unique case (state)
      S_IDLE: start_frame = fifo_vld;
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          tx_nxt    = shreg[0];
          idx_nxt   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx == bits_q - BW'(1)) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_bit_q;
            end else
`endif
            begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
              idx_nxt   = '0;
            end
          end else begin
            idx_nxt   = idx + BW'(1);
            shreg_nxt = shreg_sh;
            tx_nxt    = shreg_sh[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
          idx_nxt   = '0;
        end
      end
`endif
      S_STOP: begin
        // idx counts completed stop bits; a queued byte starts on the very next clock.
        if (bit_end) begin
          if (stop2_q && idx == '0) begin
            idx_nxt = BW'(1);
          end else if (fifo_vld) begin
            start_frame = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (start_frame) begin
      pop       = 1'b1;
      state_nxt = S_START;
      cnt_nxt   = '0;
      tx_nxt    = 1'b0;
      busy_nxt  = 1'b1;
      div_nxt   = div_eff;
      bits_nxt  = bits_eff;
      stop2_nxt = cfg_stop2;
      shreg_nxt = fifo_dat;
`ifdef UART_TX_PARITY_EN
      par_en_nxt  = (cfg_par == 2'b01) || (cfg_par == 2'b10);
      par_bit_nxt = par_calc ^ cfg_par[1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      div_q   <= DIV_W'(1);
      bits_q  <= BW'(DATA_W);
      stop2_q <= 1'b0;
      shreg   <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      div_q   <= div_nxt;
      bits_q  <= bits_nxt;
      stop2_q <= stop2_nxt;
      shreg   <= shreg_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_nxt;
      par_bit_q <= par_bit_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame waveforms from a bit-list model, FIFO flow control, reset behaviour.
module tb_uart_tx_fifo;
  localparam int DATA_W     = 8;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [DIV_W-1:0]  cfg_div;
  logic [3:0]        cfg_bits;
  logic              cfg_stop2;
  logic [1:0]        cfg_par;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx;
  logic              busy;
  logic [LW-1:0]     fifo_level;

  int checks = 0;
  int errors = 0;
  logic exp_tx[$];
  logic exp_busy[$];
  logic act_tx[$];
  logic act_busy[$];

  uart_tx_fifo #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_div    (cfg_div),
    .cfg_bits   (cfg_bits),
    .cfg_stop2  (cfg_stop2),
    .cfg_par    (cfg_par),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void clear_exp();
    exp_tx.delete();
    exp_busy.delete();
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endfunction

  // Frame = start, data LSB first, optional parity, stop bit(s); each bit held for div clocks.
  function automatic void add_frame(input logic [7:0] d, input int div, input int bits,
                                    input bit stop2, input int par);
    int   dv;
    int   nb;
    logic p;
    logic seq[$];
    dv = (div == 0) ? 1 : div;
    nb = (bits == 0 || bits > DATA_W) ? DATA_W : bits;
    p  = 1'b0;
    seq.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      seq.push_back(d[i]);
      p = p ^ d[i];
    end
    if (PAR_BUILD && (par == 1 || par == 2)) seq.push_back((par == 2) ? ~p : p);
    seq.push_back(1'b1);
    if (stop2) seq.push_back(1'b1);
    foreach (seq[k])
      for (int c = 0; c < dv; c++) begin
        exp_tx.push_back(seq[k]);
        exp_busy.push_back(1'b1);
      end
  endfunction

  function automatic int diff_at(input bit sel_busy);
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i >= act_tx.size()) return i;
      if (!sel_busy && act_tx[i] !== exp_tx[i]) return i;
      if (sel_busy && act_busy[i] !== exp_busy[i]) return i;
    end
    return -1;
  endfunction

  task automatic capture(input int n);
    act_tx.delete();
    act_busy.delete();
    repeat (n) begin
      @(negedge clk);
      act_tx.push_back(tx);
      act_busy.push_back(busy);
    end
  endtask

  // Called just after a negedge; returns at the negedge following the accepting posedge.
  task automatic push_byte(input logic [7:0] d, output int waited);
    waited   = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic set_cfg(input int div, input int bits, input bit stop2, input int par);
    cfg_div   = DIV_W'(div);
    cfg_bits  = 4'(bits);
    cfg_stop2 = stop2;
    cfg_par   = 2'(par);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL rst_tx: got %b, required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_level: got %0d, required 0", fifo_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b, required 0", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b, required 1", in_ready); end
  endtask

  task automatic test_basic();
    int w;
    int d;
    set_cfg(4, 8, 1'b0, 0);
    clear_exp(); add_idle(1); add_frame(8'hA5, 4, 8, 1'b0, 0); add_idle(3);
    fork
      push_byte(8'hA5, w);
      begin @(posedge clk); capture(exp_tx.size()); end
    join
    d = diff_at(1'b0);
    checks++; if (d >= 0) begin errors++; $display("FAIL basic_tx: cycle %0d tx=%b, required %b", d, act_tx[d], exp_tx[d]); end
    d = diff_at(1'b1);
    checks++; if (d >= 0) begin errors++; $display("FAIL basic_busy: cycle %0d busy=%b, required %b", d, act_busy[d], exp_busy[d]); end
  endtask

  task automatic test_back_to_back();
    int w1, w2, w3;
    int d;
    set_cfg(2, 8, 1'b0, 0);
    clear_exp(); add_idle(1);
    add_frame(8'h55, 2, 8, 1'b0, 0); add_frame(8'h0F, 2, 8, 1'b0, 0); add_frame(8'hF0, 2, 8, 1'b0, 0);
    add_idle(3);
    fork
      begin push_byte(8'h55, w1); push_byte(8'h0F, w2); push_byte(8'hF0, w3); end
      begin @(posedge clk); capture(exp_tx.size()); end
    join
    checks++; if (w1 + w2 + w3 != 0) begin errors++; $display("FAIL b2b_ready: stalled %0d cycles, required 0", w1 + w2 + w3); end
    d = diff_at(1'b0);
    checks++; if (d >= 0) begin errors++; $display("FAIL b2b_tx: cycle %0d tx=%b, required %b", d, act_tx[d], exp_tx[d]); end
    d = diff_at(1'b1);
    checks++; if (d >= 0) begin errors++; $display("FAIL b2b_busy: cycle %0d busy=%b, required %b", d, act_busy[d], exp_busy[d]); end
  endtask

  task automatic test_five_bits();
    int w1, w2;
    int d;
    set_cfg(3, 5, 1'b1, 0);
    clear_exp(); add_idle(1);
    add_frame(8'h1F, 3, 5, 1'b1, 0); add_frame(8'hE0, 3, 5, 1'b1, 0);
    add_idle(3);
    fork
      begin push_byte(8'h1F, w1); push_byte(8'hE0, w2); end
      begin @(posedge clk); capture(exp_tx.size()); end
    join
    d = diff_at(1'b0);
    checks++; if (d >= 0) begin errors++; $display("FAIL bits5_tx: cycle %0d tx=%b, required %b", d, act_tx[d], exp_tx[d]); end
    d = diff_at(1'b1);
    checks++; if (d >= 0) begin errors++; $display("FAIL bits5_busy: cycle %0d busy=%b, required %b", d, act_busy[d], exp_busy[d]); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int w;
    int d;
    set_cfg(3, 8, 1'b0, 2);
    clear_exp(); add_idle(1); add_frame(8'h03, 3, 8, 1'b0, 2); add_idle(3);
    fork
      push_byte(8'h03, w);
      begin @(posedge clk); capture(exp_tx.size()); end
      begin repeat (2) @(posedge clk); @(negedge clk); cfg_par = 2'b01; cfg_bits = 4'd4; end
    join
    d = diff_at(1'b0);
    checks++; if (d >= 0) begin errors++; $display("FAIL parity_tx: cycle %0d tx=%b, required %b", d, act_tx[d], exp_tx[d]); end
  endtask
`endif

  task automatic test_random();
    int w;
    int d;
    int div, bits, par;
    bit stop2;
    logic [7:0] data;
    for (int it = 0; it < 8; it++) begin
      div   = int'($urandom_range(0, 6));
      bits  = int'($urandom_range(0, 15));
      par   = int'($urandom_range(0, 3));
      stop2 = 1'($urandom_range(0, 1));
      data  = 8'($urandom);
      set_cfg(div, bits, stop2, par);
      clear_exp(); add_idle(1); add_frame(data, div, bits, stop2, par); add_idle(2);
      fork
        push_byte(data, w);
        begin @(posedge clk); capture(exp_tx.size()); end
        begin
          repeat (2) @(posedge clk);
          @(negedge clk);
          set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end
      join
      d = diff_at(1'b0);
      checks++;
      if (d >= 0) begin
        errors++;
        $display("FAIL rand_tx[%0d]: data=%h div=%0d bits=%0d stop2=%0d par=%0d cycle %0d tx=%b, required %b",
                 it, data, div, bits, stop2, par, d, act_tx[d], exp_tx[d]);
      end
    end
  endtask

  task automatic test_full_fifo();
    int w;
    int frame;
    set_cfg(100, 8, 1'b0, 0);
    clear_exp(); add_frame(8'h00, 100, 8, 1'b0, 0);
    frame = exp_tx.size();
    for (int i = 0; i < 5; i++) push_byte(8'($urandom), w);
    checks++; if (fifo_level !== LW'(FIFO_DEPTH)) begin errors++; $display("FAIL full_level: got %0d, required %0d", fifo_level, FIFO_DEPTH); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, required 0", in_ready); end
    push_byte(8'h3C, w);
    checks++; if (w != 1 + frame - 4) begin errors++; $display("FAIL full_wait: stalled %0d cycles, required %0d", w, 1 + frame - 4); end
    checks++; if (fifo_level !== LW'(FIFO_DEPTH)) begin errors++; $display("FAIL full_refill: got %0d, required %0d", fifo_level, FIFO_DEPTH); end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: tx=%b busy=%b, required 0 1", tx, busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL mid_tx: got %b, required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL mid_level: got %0d, required 0", fifo_level); end
    rst_n = 1'b1;
    clear_exp(); add_idle(60);
    capture(60);
    d = diff_at(1'b0);
    checks++; if (d >= 0) begin errors++; $display("FAIL mid_stray_tx: cycle %0d tx=%b, required 1", d, act_tx[d]); end
    d = diff_at(1'b1);
    checks++; if (d >= 0) begin errors++; $display("FAIL mid_stray_busy: cycle %0d busy=%b, required 0", d, act_busy[d]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, required 1", in_ready); end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    set_cfg(1, 8, 1'b0, 0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_five_bits();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_full_fifo();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
